// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared types and elaboration helpers for the button event decoder
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } btn_state_t;

  function automatic int ms_to_cycles(input int clk_freq_hz, input int ms);
    return clk_freq_hz / 1000 * ms;
  endfunction

  function automatic int timer_width(input int long_cyc, input int gap_cyc);
    int max_cyc;
    max_cyc = (long_cyc > gap_cyc) ? long_cyc : gap_cyc;
    return $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/button_event_decoder_debouncer.sv
// rtl/button_event_decoder_debouncer.sv - synchronizer, polarity handling and debounce counter
module button_debouncer #(
  parameter int DEB_CYC   = 200000,
  parameter bit IS_PULLUP = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  output logic btn_level
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic [1:0]    sync;
  logic          sample;
  logic [CW-1:0] cnt;

  // Synchronizer resets to the raw "released" level so the first sample is not a press.
  assign sample = sync[1] ^ IS_PULLUP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync      <= {2{IS_PULLUP}};
      cnt       <= '0;
      btn_level <= 1'b0;
    end else begin
      sync <= {sync[0], push_button};
      if (sample == btn_level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        cnt       <= '0;
        btn_level <= sample;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - classifies debounced presses into short, long and double events
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 10_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter int DOUBLE_GAP_MS = 300,
  parameter int IS_PULLUP     = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  output logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  localparam int DEB_CYC  = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
  localparam int GAP_CYC  = ms_to_cycles(CLK_FREQ_HZ, DOUBLE_GAP_MS);
  localparam int TW       = timer_width(LONG_CYC, GAP_CYC);

  // The FSM enters a state one cycle after btn_level moves and the event is registered,
  // so the timer compare sits two below the threshold to land the pulse on time.
  localparam logic [TW-1:0] LONG_HIT = TW'((LONG_CYC >= 2) ? LONG_CYC - 2 : 0);
  localparam logic [TW-1:0] GAP_HIT  = TW'((GAP_CYC >= 2) ? GAP_CYC - 2 : 0);

  if (DEB_CYC < 1 || LONG_CYC < 1 || GAP_CYC < 1) begin : g_bad_params
    $error("button_event_decoder: derived cycle counts must be at least 1");
  end

  btn_state_t    state, state_next;
  logic [TW-1:0] timer;
  logic          level_q;
  logic          rise, fall;
  logic          short_next, long_next, double_next;

  button_debouncer #(
    .DEB_CYC  (DEB_CYC),
    .IS_PULLUP(IS_PULLUP != 0)
  ) u_debouncer (
    .clk        (clk),
    .rst        (rst),
    .push_button(push_button),
    .btn_level  (btn_level)
  );

  assign rise = btn_level & ~level_q;
  assign fall = ~btn_level & level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      timer        <= '0;
      level_q      <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      level_q      <= btn_level;
      short_press  <= short_next;
      long_press   <= long_next;
      double_press <= double_next;
      busy         <= (state_next != IDLE);
      if (state_next != state) begin
        timer <= '0;
      end else if (timer != {TW{1'b1}}) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Edge checks come before timer checks so a coincident release/press wins the race.
  always_comb begin
    state_next  = state;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_next = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_next = WAIT2;
        end else if (timer == LONG_HIT) begin
          long_next  = 1'b1;
          state_next = HOLD;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_next = PRESS2;
        end else if (timer == GAP_HIT) begin
          short_next = 1'b1;
          state_next = IDLE;
        end
      end
      PRESS2: begin
        if (fall) begin
          double_next = 1'b1;
          state_next  = IDLE;
        end else if (timer == LONG_HIT) begin
          double_next = 1'b1;
          state_next  = HOLD;
        end
      end
      HOLD: begin
        if (fall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - self-checking bench for button_event_decoder
module tb_button_event_decoder;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int GAP  = 8;
  localparam int N    = 2000;
  localparam int BIG  = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic push = 1'b0;
  logic pu_push = 1'b1;
  logic level, sp, lp, dp, busy;
  logic pu_level, pu_sp, pu_lp, pu_dp, pu_busy;

  int checks = 0;
  int failures = 0;

  button_event_decoder #(
    .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .LONG_PRESS_MS(20), .DOUBLE_GAP_MS(8), .IS_PULLUP(0)
  ) dut (
    .clk(clk), .rst(rst), .push_button(push), .btn_level(level),
    .short_press(sp), .long_press(lp), .double_press(dp), .busy(busy)
  );

  button_event_decoder #(
    .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .LONG_PRESS_MS(20), .DOUBLE_GAP_MS(8), .IS_PULLUP(1)
  ) dut_pu (
    .clk(clk), .rst(rst), .push_button(pu_push), .btn_level(pu_level),
    .short_press(pu_sp), .long_press(pu_lp), .double_press(pu_dp), .busy(pu_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // kind codes: 0 none, 1 short, 2 long, 3 double
  typedef struct {
    int hi1;
    int lo;
    int hi2;
    int kind;
    int at;
    int count;
  } row_t;

  row_t rows[8];

  function automatic logic row_input(input row_t r, input int t);
    if (t < r.hi1) return 1'b1;
    if (r.hi2 == 0) return 1'b0;
    if (t < r.hi1 + r.lo) return 1'b0;
    if (t < r.hi1 + r.lo + r.hi2) return 1'b1;
    return 1'b0;
  endfunction

  int p[N];
  logic mlv[N];
  logic esp[N], elp[N], edp[N], ebusy[N];
  logic dlv[N], dsp[N], dlp[N], ddp[N], dbusy[N];

  task automatic mark(input int kind, input int t);
    if (t >= 0 && t < N) begin
      if (kind == 1) esp[t] = 1'b1;
      if (kind == 2) elp[t] = 1'b1;
      if (kind == 3) edp[t] = 1'b1;
    end
  endtask

  // Reference: debounce as "last DEB synchronized samples all disagree", then
  // classify each gesture from the list of debounced press intervals.
  task automatic build_model();
    int rq[$];
    int fq[$];
    int i, idle_at, r1, f1, r2, f2, fin;
    logic prev, tog, s;
    for (int t = 0; t < N; t++) begin
      prev = (t > 0) ? mlv[t-1] : 1'b0;
      tog = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        s = (t - 3 - j >= 0) ? p[t-3-j][0] : 1'b0;
        if (s == prev) tog = 1'b0;
      end
      mlv[t] = tog ? ~prev : prev;
      esp[t] = 1'b0; elp[t] = 1'b0; edp[t] = 1'b0; ebusy[t] = 1'b0;
      if (mlv[t] && !prev) rq.push_back(t);
      if (!mlv[t] && prev) fq.push_back(t);
    end
    if (rq.size() > fq.size()) fq.push_back(BIG);
    i = 0;
    idle_at = 0;
    while (i < rq.size()) begin
      r1 = rq[i];
      f1 = fq[i];
      if (r1 < idle_at) begin
        i++;
        continue;
      end
      if (f1 >= r1 + LONG) begin
        mark(2, r1 + LONG);
        fin = f1 + 1;
        i++;
      end else if (i + 1 < rq.size() && rq[i+1] <= f1 + GAP - 1) begin
        r2 = rq[i+1];
        f2 = fq[i+1];
        mark(3, (f2 >= r2 + LONG) ? r2 + LONG : f2 + 1);
        fin = f2 + 1;
        i += 2;
      end else begin
        mark(1, f1 + GAP);
        fin = f1 + GAP;
        i++;
      end
      for (int c = r1 + 1; c < fin && c < N; c++) ebusy[c] = 1'b1;
      idle_at = fin;
    end
  endtask

  initial begin
    int first_at, first_kind, cnt, multi, rise_at, n, seen_lvl, seen_pulse, seg, len, lvl_val;

    rows[0] = '{10, 0, 0, 1, 24, 1};
    rows[1] = '{30, 0, 0, 2, 26, 1};
    rows[2] = '{5, 5, 5, 3, 22, 1};
    rows[3] = '{5, 7, 5, 3, 24, 1};
    rows[4] = '{5, 8, 5, 1, 19, 2};
    rows[5] = '{19, 0, 0, 1, 33, 1};
    rows[6] = '{20, 0, 0, 2, 26, 1};
    rows[7] = '{5, 5, 25, 3, 36, 1};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_level", level, 0);
    check("reset_short", sp, 0);
    check("reset_long", lp, 0);
    check("reset_double", dp, 0);
    check("reset_busy", busy, 0);
    check("reset_pu_level", pu_level, 0);
    check("reset_pu_busy", pu_busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int t = 0; t < 10; t++) begin @(posedge clk); #1; end

    // bounce rejection: repeated 3-cycle glitches
    seen_lvl = 0;
    seen_pulse = 0;
    for (int t = 0; t < 50; t++) begin
      push = ((t % 6) < 3) && (t < 36);
      @(negedge clk);
      if (level) seen_lvl++;
      if (sp || lp || dp || busy) seen_pulse++;
      @(posedge clk); #1;
    end
    check("bounce_level", seen_lvl, 0);
    check("bounce_events", seen_pulse, 0);

    // table-driven gestures
    foreach (rows[r]) begin
      first_at = -1; first_kind = 0; cnt = 0; multi = 0; rise_at = -1;
      for (int t = 0; t < 70; t++) begin
        push = row_input(rows[r], t);
        @(negedge clk);
        if (level && rise_at < 0) rise_at = t;
        n = int'(sp) + int'(lp) + int'(dp);
        if (n > 1) multi++;
        if (n > 0) begin
          cnt++;
          if (first_at < 0) begin
            first_at = t;
            first_kind = sp ? 1 : (lp ? 2 : 3);
          end
        end
        @(posedge clk); #1;
      end
      check($sformatf("row%0d_rise", r), rise_at, 6);
      check($sformatf("row%0d_kind", r), first_kind, rows[r].kind);
      check($sformatf("row%0d_at", r), first_at, rows[r].at);
      check($sformatf("row%0d_count", r), cnt, rows[r].count);
      check($sformatf("row%0d_exclusive", r), multi, 0);
      check($sformatf("row%0d_busy_end", r), busy, 0);
    end

    // reset mid-PRESS1 on the pull-up instance, button held through reset
    rise_at = -1;
    for (int t = 0; t < 16; t++) begin
      pu_push = 1'b0;
      @(negedge clk);
      if (pu_level && rise_at < 0) rise_at = t;
      if (t == 15) check("pu_busy_before_reset", pu_busy, 1);
      @(posedge clk); #1;
    end
    check("pu_rise_before_reset", rise_at, 6);
    rst = 1'b0;
    #1;
    check("rst_pu_level", pu_level, 0);
    check("rst_pu_busy", pu_busy, 0);
    check("rst_pu_pulses", {pu_sp, pu_lp, pu_dp}, 0);
    check("rst_main_outputs", {level, sp, lp, dp, busy}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rise_at = -1; cnt = 0; first_at = -1; first_kind = 0;
    for (int t = 0; t < 40; t++) begin
      pu_push = (t < 10) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (pu_level && rise_at < 0) rise_at = t;
      if (pu_sp || pu_lp || pu_dp) begin
        cnt++;
        if (first_at < 0) begin
          first_at = t;
          first_kind = pu_sp ? 1 : (pu_lp ? 2 : 3);
        end
      end
      @(posedge clk); #1;
    end
    check("pu_rise_after_reset", rise_at, 6);
    check("pu_event_count", cnt, 1);
    check("pu_event_kind", first_kind, 1);
    check("pu_event_at", first_at, 24);
    check("pu_busy_end", pu_busy, 0);

    // randomized run against the reference model
    push = 1'b0;
    for (int t = 0; t < 40; t++) begin @(posedge clk); #1; end
    seg = 0;
    lvl_val = 0;
    while (seg < N) begin
      lvl_val = 1 - lvl_val;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 30));
      for (int k = 0; k < len && seg < N; k++) begin
        p[seg] = lvl_val;
        seg++;
      end
    end
    for (int t = 0; t < N; t++) begin
      push = p[t][0];
      @(negedge clk);
      dlv[t] = level; dsp[t] = sp; dlp[t] = lp; ddp[t] = dp; dbusy[t] = busy;
      @(posedge clk); #1;
    end
    build_model();
    for (int t = 0; t < N; t++) begin
      check($sformatf("rand_level@%0d", t), dlv[t], mlv[t]);
      check($sformatf("rand_short@%0d", t), dsp[t], esp[t]);
      check($sformatf("rand_long@%0d", t), dlp[t], elp[t]);
      check($sformatf("rand_double@%0d", t), ddp[t], edp[t]);
      check($sformatf("rand_busy@%0d", t), dbusy[t], ebusy[t]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
